nvdla_sdp_y_lut_rd_sched: RTL and testbench
===========================================

# nvdla_sdp_y_lut_rd_sched

Sequences reads of the shared Y-channel LUT RAMs (LE table, 65 entries; LO table, 257 entries) for the index stage that follows the Y-path index computation, and arbitrates the same single-port RAMs with the register-side LUT programming port. Per packet it fetches the entry pair {addr, addr+1} for every lane, serialised over one RAM port, and presents the pairs to the interpolation stage.

## Interface
- LANES, 1, element lanes per packet (equals SDP EW throughput)
- ENTRY_W, 16, LUT entry width
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset; one clock; reset is synchronous and active-low
- idx_in_pvld / idx_in_prdy  in / out  1  index packet handshake
- idx_in_pd  in  LANES*10  lane i: [10i+8:10i] addr, [10i+9] sel (0=LE, 1=LO)
- lut_out_pvld / lut_out_prdy  out / in  1  entry-pair handshake
- lut_out_pd  out  LANES*2*ENTRY_W  lane i: low half entry(addr), high half entry(addr+1)
- cfg_lut_access_pvld / cfg_lut_access_prdy  in / out  1  programming request handshake
- cfg_lut_access_wr  in  1  1=write, 0=read
- cfg_lut_access_sel  in  1  table select
- cfg_lut_access_addr  in  9  entry index
- cfg_lut_access_wdata  in  ENTRY_W  write data
- cfg_lut_rdata_pvld  out  1  one-cycle pulse, no backpressure
- cfg_lut_rdata  out  ENTRY_W  read data
- ram_rd_en / ram_wr_en  out  1  RAM strobes (never both high)
- ram_sel  out  1  table select
- ram_addr  out  9  entry index
- ram_wdata  out  ENTRY_W
- ram_rd_data  in  ENTRY_W  valid in the cycle after ram_rd_en

## Operation
- FSM states: IDLE, RD, WAIT, OUT, CFG, CFG_RET.
- IDLE: if cfg_lut_access_pvld, then cfg_lut_access_prdy=1 and go to CFG (config has fixed priority). Else if idx_in_pvld, then idx_in_prdy=1; latch pd; go to RD.
- idx_in_prdy = 1 only in IDLE with cfg_lut_access_pvld low. cfg_lut_access_prdy = 1 only in IDLE.
- Clamp: addr is clamped to max index (LE 64, LO 256). Entry hi index = min(addr+1, max).
- RD: issue one read per cycle, lane 0 first, lo then hi; counter tracks reads. After the last issue go to WAIT.
- WAIT: capture the final return, then go to OUT. Every return is registered into its pd slot at the end of the cycle after issue.
- OUT: lut_out_pvld=1 with pd held stable; on lut_out_prdy go to IDLE.
- CFG: drive ram_wr_en or ram_rd_en for one cycle using the request fields. A write then goes to IDLE; a read goes to CFG_RET.
- CFG_RET: cfg_lut_rdata_pvld=1 with ram_rd_data; go to IDLE.

## Timing
- Reset: state=IDLE. All handshake outputs, ram strobes, and cfg_lut_rdata_pvld are 0. lut_out_pd, cfg_lut_rdata, ram_addr, ram_sel, and ram_wdata are 0. Any in-flight ram_rd_data is discarded.
- Packet accepted in cycle 0:
  - Reads are issued in cycles 1..N.
  - lut_out_pvld rises in cycle N+2.
  - N = 2*LANES minus skipped reads (see Configuration).
- Packets are not pipelined: the next accept comes no earlier than the cycle after the lut_out handshake.
- Simultaneous cfg and idx requests in IDLE: cfg wins. idx is accepted in the first IDLE cycle after the cfg sequence.
- Config access accepted in cycle c: the RAM strobe is in cycle c+1. For a read, the rdata pulse is in cycle c+2.
- Reset asserted mid-packet: abort immediately; no partial output.

## Configuration
- NVDLA_SDP_LUT_PAIR_SKIP_EN defined: when hi index == lo index (addr at or beyond max), the hi read is skipped and the lo data is duplicated into the hi half. N shrinks by 1 per such lane.
- Undefined: the hi read is always issued (to the clamped index). N = 2*LANES always.
- lut_out_pd contents are identical in both builds; only cycle counts differ.

## Structure
- Shared package holds:
  - LE_MAX=64, LO_MAX=256
  - ENTRY_W
  - lane pd field offsets
  - state enum
- One sub-module: nvdla_sdp_y_lut_addr_gen, combinational per lane. Takes {sel, addr} and produces clamped lo/hi indices and a skip flag.

## Test plan
- LANES=1, LO addr 10 (RAM LO[10]=0x1234, LO[11]=0x5678) -> reads LO10@1, LO11@2; pvld@4; pd=0x56781234.
- LE addr 64 with macro -> single read LE64, pvld@3, pd={LE64,LE64}. Without macro -> two reads of LE64, pvld@4, same pd.
- LO addr 300 -> both halves LO[256]; no ram_addr above 256 ever issued.
- cfg write LE5=0xBEEF arriving with idx_in_pvld in IDLE:
  - ram_wr_en@1; idx accepted @2.
  - A following cfg read LE5 returns a 0xBEEF pulse 2 cycles after its accept.
- LANES=2, lut_out_prdy held low 5 cycles -> pd stable, pvld held, idx_in_prdy=0 throughout; release -> next packet accepted the next cycle.
- Reset pulsed during RD -> all outputs 0 next cycle; a subsequent packet returns correct data with nominal latency.

Source files
------------

// File: rtl/nvdla_sdp_y_lut_rd_sched_pkg.sv
// Purpose : shared constants, lane field layout and FSM encoding for the Y-LUT read scheduler.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Ports: none. Optional feature macro used by this slice: NVDLA_SDP_LUT_PAIR_SKIP_EN.
package nvdla_sdp_y_lut_rd_sched_pkg;

   // Default LUT entry width; the top exposes it as the ENTRY_W parameter.
   localparam int LUT_ENTRY_W = 16;

   // Highest valid entry index of each table (LE: 65 entries, LO: 257 entries).
   localparam logic [8:0] LE_MAX = 9'd64;
   localparam logic [8:0] LO_MAX = 9'd256;

   // Per-lane layout of idx_in_pd: [8:0] addr, [9] sel (0=LE, 1=LO).
   localparam int IDX_W       = 9;
   localparam int PD_LANE_W   = 10;
   localparam int PD_ADDR_LSB = 0;
   localparam int PD_SEL_BIT  = 9;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      WAIT    = 3'd2,
      OUT     = 3'd3,
      CFG     = 3'd4,
      CFG_RET = 3'd5
   } state_t;

endpackage

// File: rtl/nvdla_sdp_y_lut_addr_gen.sv
// Purpose : per-lane index clamp; yields the lo/hi entry indices of an interpolation pair.
// Latency : combinational.
// Backpressure: none (pure function of {sel, addr}).
// Ports: sel/addr in; lo_idx = min(addr, max), hi_idx = min(lo_idx+1, max), skip = (hi_idx == lo_idx).
module nvdla_sdp_y_lut_addr_gen
   import nvdla_sdp_y_lut_rd_sched_pkg::*;
(
   input  logic             sel,
   input  logic [IDX_W-1:0] addr,
   output logic [IDX_W-1:0] lo_idx,
   output logic [IDX_W-1:0] hi_idx,
   output logic             skip
);

   logic [IDX_W-1:0] max_idx;
   logic [IDX_W:0]   inc_idx;

   always_comb begin
      max_idx = sel ? LO_MAX : LE_MAX;
      lo_idx  = (addr > max_idx) ? max_idx : addr;
      // One extra bit so lo_idx+1 cannot wrap before the compare.
      inc_idx = {1'b0, lo_idx} + {{IDX_W{1'b0}}, 1'b1};
      hi_idx  = (inc_idx > {1'b0, max_idx}) ? max_idx : inc_idx[IDX_W-1:0];
      // Both halves point at the last entry: the second read would be redundant.
      skip    = (hi_idx == lo_idx);
   end

endmodule

// File: rtl/nvdla_sdp_y_lut_rd_sched.sv
// Purpose : serialises per-lane LUT entry-pair reads over one RAM port and arbitrates it with cfg access.
// Latency : packet accepted in cycle 0 -> reads in cycles 1..N -> lut_out_pvld in cycle N+2; cfg strobe c+1, rdata c+2.
// Backpressure: one packet in flight; idx_in_prdy only in IDLE without a cfg request; output held until lut_out_prdy.
// Ports: idx_in_* index packets; lut_out_* entry pairs (lane i: {entry(hi), entry(lo)});
//        cfg_lut_access_* / cfg_lut_rdata* programming port; ram_* single-port LUT RAM.
// Optional feature macro: NVDLA_SDP_LUT_PAIR_SKIP_EN (skip the redundant hi read of a clamped lane).
module nvdla_sdp_y_lut_rd_sched
   import nvdla_sdp_y_lut_rd_sched_pkg::*;
#(
   parameter int LANES   = 1,
   parameter int ENTRY_W = LUT_ENTRY_W
)
(
   input  logic                         nvdla_core_clk,
   input  logic                         nvdla_core_rstn,
   input  logic                         idx_in_pvld,
   output logic                         idx_in_prdy,
   input  logic [LANES*PD_LANE_W-1:0]   idx_in_pd,
   output logic                         lut_out_pvld,
   input  logic                         lut_out_prdy,
   output logic [LANES*2*ENTRY_W-1:0]   lut_out_pd,
   input  logic                         cfg_lut_access_pvld,
   output logic                         cfg_lut_access_prdy,
   input  logic                         cfg_lut_access_wr,
   input  logic                         cfg_lut_access_sel,
   input  logic [IDX_W-1:0]             cfg_lut_access_addr,
   input  logic [ENTRY_W-1:0]           cfg_lut_access_wdata,
   output logic                         cfg_lut_rdata_pvld,
   output logic [ENTRY_W-1:0]           cfg_lut_rdata,
   output logic                         ram_rd_en,
   output logic                         ram_wr_en,
   output logic                         ram_sel,
   output logic [IDX_W-1:0]             ram_addr,
   output logic [ENTRY_W-1:0]           ram_wdata,
   input  logic [ENTRY_W-1:0]           ram_rd_data
);

   // Read slots: slot 2i = lane i lo entry, slot 2i+1 = lane i hi entry.
   localparam int NSLOT = 2 * LANES;
   // Counter may step by 2 past the last slot, so keep headroom above NSLOT.
   localparam int CNT_W = $clog2(NSLOT) + 1;
   localparam int PD_W  = LANES * 2 * ENTRY_W;

   state_t                     state_q, state_d;
   logic [LANES*PD_LANE_W-1:0] idx_pd_q;
   logic [CNT_W-1:0]           rd_cnt_q, cnt_d;
   logic                       ret_vld_q;
   logic [CNT_W-1:0]           ret_slot_q;
   logic                       ret_dup_q;
   logic [PD_W-1:0]            out_pd_q;
   logic                       cfg_wr_q;
   logic                       cfg_sel_q;
   logic [IDX_W-1:0]           cfg_addr_q;
   logic [ENTRY_W-1:0]         cfg_wdata_q;

   logic                       idx_acc;
   logic                       cfg_acc;
   logic                       rd_issue;
   logic                       issue_dup;

   logic [IDX_W-1:0]           lo_idx [LANES];
   logic [IDX_W-1:0]           hi_idx [LANES];
   logic [LANES-1:0]           lane_sel;
   logic [LANES-1:0]           skip_lane;
   logic [LANES-1:0]           skip_en;

   logic [IDX_W-1:0]           cur_lo;
   logic [IDX_W-1:0]           cur_hi;
   logic                       cur_sel;
   logic                       cur_skip;
   logic                       cur_is_hi;

   // ------------------------------------------------------------------
   // Per-lane index clamp on the latched packet
   // ------------------------------------------------------------------
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_sel[i] = idx_pd_q[i*PD_LANE_W + PD_SEL_BIT];

      nvdla_sdp_y_lut_addr_gen u_addr_gen (
         .sel    (lane_sel[i]),
         .addr   (idx_pd_q[i*PD_LANE_W + PD_ADDR_LSB +: IDX_W]),
         .lo_idx (lo_idx[i]),
         .hi_idx (hi_idx[i]),
         .skip   (skip_lane[i])
      );
   end

`ifdef NVDLA_SDP_LUT_PAIR_SKIP_EN
   assign skip_en = skip_lane;
`else
   // Hi read is always issued; the clamp already points it at the last entry.
   assign skip_en = '0;
   logic unused_skip;
   assign unused_skip = ^skip_lane;
`endif

   // Lane addressed by the read counter.
   assign cur_is_hi = rd_cnt_q[0];

   always_comb begin
      cur_lo   = '0;
      cur_hi   = '0;
      cur_sel  = 1'b0;
      cur_skip = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (int'(rd_cnt_q >> 1) == i) begin
            cur_lo   = lo_idx[i];
            cur_hi   = hi_idx[i];
            cur_sel  = lane_sel[i];
            cur_skip = skip_en[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d             = state_q;
      idx_in_prdy         = 1'b0;
      cfg_lut_access_prdy = 1'b0;
      lut_out_pvld        = 1'b0;
      cfg_lut_rdata_pvld  = 1'b0;
      cfg_lut_rdata       = '0;
      ram_rd_en           = 1'b0;
      ram_wr_en           = 1'b0;
      ram_sel             = 1'b0;
      ram_addr            = '0;
      ram_wdata           = '0;
      idx_acc             = 1'b0;
      cfg_acc             = 1'b0;
      rd_issue            = 1'b0;
      issue_dup           = 1'b0;
      cnt_d               = rd_cnt_q;

      unique case (state_q)
         IDLE: begin
            // Readies are held low while reset is asserted.
            cfg_lut_access_prdy = nvdla_core_rstn;
            idx_in_prdy         = nvdla_core_rstn & ~cfg_lut_access_pvld;
            if (cfg_lut_access_pvld) begin
               cfg_acc = 1'b1;
               state_d = CFG;
            end else if (idx_in_pvld) begin
               idx_acc = 1'b1;
               state_d = RD;
            end
         end
         RD: begin
            rd_issue  = 1'b1;
            ram_rd_en = 1'b1;
            ram_sel   = cur_sel;
            ram_addr  = cur_is_hi ? cur_hi : cur_lo;
            // A skipped lane's lo data also fills its hi slot.
            issue_dup = ~cur_is_hi & cur_skip;
            cnt_d     = rd_cnt_q + (issue_dup ? CNT_W'(2) : CNT_W'(1));
            if (cnt_d >= CNT_W'(NSLOT)) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            state_d = OUT;
         end
         OUT: begin
            lut_out_pvld = 1'b1;
            if (lut_out_prdy) begin
               state_d = IDLE;
            end
         end
         CFG: begin
            ram_sel  = cfg_sel_q;
            ram_addr = cfg_addr_q;
            if (cfg_wr_q) begin
               ram_wr_en = 1'b1;
               ram_wdata = cfg_wdata_q;
               state_d   = IDLE;
            end else begin
               ram_rd_en = 1'b1;
               state_d   = CFG_RET;
            end
         end
         CFG_RET: begin
            cfg_lut_rdata_pvld = 1'b1;
            cfg_lut_rdata      = ram_rd_data;
            state_d            = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: request latches, read counter, return capture
   // ------------------------------------------------------------------
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         idx_pd_q    <= '0;
         rd_cnt_q    <= '0;
         ret_vld_q   <= 1'b0;
         ret_slot_q  <= '0;
         ret_dup_q   <= 1'b0;
         out_pd_q    <= '0;
         cfg_wr_q    <= 1'b0;
         cfg_sel_q   <= 1'b0;
         cfg_addr_q  <= '0;
         cfg_wdata_q <= '0;
      end else begin
         if (idx_acc) begin
            idx_pd_q <= idx_in_pd;
         end
         if (cfg_acc) begin
            cfg_wr_q    <= cfg_lut_access_wr;
            cfg_sel_q   <= cfg_lut_access_sel;
            cfg_addr_q  <= cfg_lut_access_addr;
            cfg_wdata_q <= cfg_lut_access_wdata;
         end

         if (idx_acc) begin
            rd_cnt_q <= '0;
         end else if (rd_issue) begin
            rd_cnt_q <= cnt_d;
         end

         // RAM data appears the cycle after the strobe; remember where it goes.
         ret_vld_q  <= rd_issue;
         ret_slot_q <= rd_cnt_q;
         ret_dup_q  <= issue_dup;

         if (ret_vld_q) begin
            for (int s = 0; s < NSLOT; s++) begin
               if ((int'(ret_slot_q) == s) ||
                   (ret_dup_q && (int'(ret_slot_q) + 1 == s))) begin
                  out_pd_q[s*ENTRY_W +: ENTRY_W] <= ram_rd_data;
               end
            end
         end
      end
   end

   assign lut_out_pd = out_pd_q;

endmodule

// File: tb/tb_nvdla_sdp_y_lut_rd_sched.sv
module tb_nvdla_sdp_y_lut_rd_sched;

   localparam int LANES = 2;
   localparam int LIM   = 64;
`ifdef NVDLA_SDP_LUT_PAIR_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        idx_in_pvld;
   logic        idx_in_prdy;
   logic [19:0] idx_in_pd;
   logic        lut_out_pvld;
   logic        lut_out_prdy;
   logic [63:0] lut_out_pd;
   logic        cfg_pvld;
   logic        cfg_prdy;
   logic        cfg_wr;
   logic        cfg_sel;
   logic [8:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        cfg_rdata_pvld;
   logic [15:0] cfg_rdata;
   logic        ram_rd_en;
   logic        ram_wr_en;
   logic        ram_sel;
   logic [8:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rd_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int last_acc = 0;
   int last_hs  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nvdla_sdp_y_lut_rd_sched #(.LANES(LANES), .ENTRY_W(16)) dut (
      .nvdla_core_clk       (clk),
      .nvdla_core_rstn      (rstn),
      .idx_in_pvld          (idx_in_pvld),
      .idx_in_prdy          (idx_in_prdy),
      .idx_in_pd            (idx_in_pd),
      .lut_out_pvld         (lut_out_pvld),
      .lut_out_prdy         (lut_out_prdy),
      .lut_out_pd           (lut_out_pd),
      .cfg_lut_access_pvld  (cfg_pvld),
      .cfg_lut_access_prdy  (cfg_prdy),
      .cfg_lut_access_wr    (cfg_wr),
      .cfg_lut_access_sel   (cfg_sel),
      .cfg_lut_access_addr  (cfg_addr),
      .cfg_lut_access_wdata (cfg_wdata),
      .cfg_lut_rdata_pvld   (cfg_rdata_pvld),
      .cfg_lut_rdata        (cfg_rdata),
      .ram_rd_en            (ram_rd_en),
      .ram_wr_en            (ram_wr_en),
      .ram_sel              (ram_sel),
      .ram_addr             (ram_addr),
      .ram_wdata            (ram_wdata),
      .ram_rd_data          (ram_rd_data)
   );

   // Power-up contents of both tables.
   function automatic logic [15:0] ram_init(input logic s, input int idx);
      return 16'((idx * 40503 + (s ? 12345 : 777)) & 32'hFFFF);
   endfunction

   // ---------------- RAM model (single port, 1-cycle read) ----------------
   logic [15:0] le_ram [65];
   logic [15:0] lo_ram [257];
   bit          le_v   [65];
   bit          lo_v   [257];

   function automatic logic [15:0] ram_read(input logic s, input int idx);
      if (s) return (idx <= 256) ? (lo_v[idx] ? lo_ram[idx] : ram_init(1'b1, idx)) : 16'hDEAD;
      return (idx <= 64) ? (le_v[idx] ? le_ram[idx] : ram_init(1'b0, idx)) : 16'hDEAD;
   endfunction

   always @(posedge clk) begin
      if (ram_wr_en) begin
         if (ram_sel && ram_addr <= 9'd256) begin
            lo_ram[ram_addr] <= ram_wdata;
            lo_v[ram_addr]   <= 1'b1;
         end else if (!ram_sel && ram_addr <= 9'd64) begin
            le_ram[ram_addr[6:0]] <= ram_wdata;
            le_v[ram_addr[6:0]]   <= 1'b1;
         end
      end
      if (ram_rd_en) ram_rd_data <= ram_read(ram_sel, int'(ram_addr));
      else           ram_rd_data <= 16'($urandom);
   end

   // ---------------- read-issue log ----------------
   typedef struct { int c; logic sel; int addr; } rd_ev_t;
   rd_ev_t rd_log [$];
   rd_ev_t ev;
   bit     both_seen = 1'b0;

   always @(negedge clk) begin
      if (ram_rd_en) begin
         ev.c = cyc; ev.sel = ram_sel; ev.addr = int'(ram_addr);
         rd_log.push_back(ev);
      end
      if (ram_rd_en && ram_wr_en) both_seen = 1'b1;
   end

   // ---------------- reference model of table contents ----------------
   logic [15:0] sh_le [65];
   logic [15:0] sh_lo [257];
   bit          sh_le_v [65];
   bit          sh_lo_v [257];

   function automatic logic [15:0] mdl_entry(input logic s, input int idx);
      if (s) return sh_lo_v[idx] ? sh_lo[idx] : ram_init(1'b1, idx);
      return sh_le_v[idx] ? sh_le[idx] : ram_init(1'b0, idx);
   endfunction

   function automatic logic [19:0] mk_pd(input logic s0, input int a0, input logic s1, input int a1);
      return {s1, 9'(a1), s0, 9'(a0)};
   endfunction

   task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic cfg_write(input logic s, input int a, input logic [15:0] d);
      int t;
      cfg_pvld = 1'b1; cfg_wr = 1'b1; cfg_sel = s; cfg_addr = 9'(a); cfg_wdata = d;
      #1;
      t = 0;
      while (!cfg_prdy && t < LIM) begin tick(); t++; end
      check(64'(t < LIM), 1, "cfg_wr_accept_timeout");
      tick();
      cfg_pvld = 1'b0;
      check(ram_wr_en, 1, "cfg_wr_strobe");
      check(ram_rd_en, 0, "cfg_wr_no_rd");
      check({ram_sel, ram_addr}, {s, 9'(a)}, "cfg_wr_addr");
      check(ram_wdata, d, "cfg_wr_data");
      if (s) begin sh_lo[a] = d; sh_lo_v[a] = 1'b1; end
      else   begin sh_le[a] = d; sh_le_v[a] = 1'b1; end
      tick();
      check(ram_wr_en, 0, "cfg_wr_single");
   endtask

   task automatic cfg_read(input logic s, input int a);
      int t;
      cfg_pvld = 1'b1; cfg_wr = 1'b0; cfg_sel = s; cfg_addr = 9'(a); cfg_wdata = 16'h0;
      #1;
      t = 0;
      while (!cfg_prdy && t < LIM) begin tick(); t++; end
      check(64'(t < LIM), 1, "cfg_rd_accept_timeout");
      tick();
      cfg_pvld = 1'b0;
      check(ram_rd_en, 1, "cfg_rd_strobe");
      check({ram_sel, ram_addr}, {s, 9'(a)}, "cfg_rd_addr");
      check(cfg_rdata_pvld, 0, "cfg_rd_early");
      tick();
      check(cfg_rdata_pvld, 1, "cfg_rd_pulse");
      check(cfg_rdata, mdl_entry(s, a), "cfg_rd_data");
      tick();
      check(cfg_rdata_pvld, 0, "cfg_rd_pulse_end");
   endtask

   task automatic run_pkt(input logic [19:0] pd, input int stall, input bit nxt_vld,
                          input logic [19:0] nxt_pd, input bit b2b);
      int t, acc, n, base, a, mx, lo, hi;
      logic s;
      logic [63:0] exp_pd;
      int rsel [4];
      int raddr [4];
      n = 0; exp_pd = '0;
      for (int l = 0; l < LANES; l++) begin
         s  = pd[10*l+9];
         a  = int'(pd[10*l +: 9]);
         mx = s ? 256 : 64;
         lo = (a > mx) ? mx : a;
         hi = (lo + 1 > mx) ? mx : lo + 1;
         exp_pd[32*l +: 16]      = mdl_entry(s, lo);
         exp_pd[32*l + 16 +: 16] = mdl_entry(s, hi);
         rsel[n] = int'(s); raddr[n] = lo; n++;
         if (!(SKIP && hi == lo)) begin rsel[n] = int'(s); raddr[n] = hi; n++; end
      end
      idx_in_pvld = 1'b1; idx_in_pd = pd;
      #1;
      t = 0;
      while (!idx_in_prdy && t < LIM) begin tick(); t++; end
      check(64'(t < LIM), 1, "idx_accept_timeout");
      acc = cyc; last_acc = acc;
      if (b2b) check(acc, last_hs + 1, "b2b_accept_cycle");
      base = rd_log.size();
      tick();
      idx_in_pvld = 1'b0;
      t = 0;
      while (!lut_out_pvld && t < LIM) begin tick(); t++; end
      check(cyc, acc + n + 2, "pvld_latency");
      check(lut_out_pd, exp_pd, "lut_out_pd");
      check(rd_log.size() - base, n, "read_count");
      for (int k = 0; k < n && base + k < rd_log.size(); k++) begin
         check({rd_log[base+k].sel}, rsel[k], "read_sel");
         check(rd_log[base+k].addr, raddr[k], "read_addr");
         check(rd_log[base+k].c, acc + 1 + k, "read_cycle");
      end
      if (nxt_vld) begin idx_in_pvld = 1'b1; idx_in_pd = nxt_pd; end
      for (int k = 0; k < stall; k++) begin
         #1;
         check(lut_out_pvld, 1, "stall_pvld");
         check(lut_out_pd, exp_pd, "stall_pd");
         check(idx_in_prdy, 0, "stall_idx_prdy");
         tick();
      end
      lut_out_prdy = 1'b1;
      #1;
      check(lut_out_pvld, 1, "hs_pvld");
      last_hs = cyc;
      tick();
      lut_out_prdy = 1'b0;
      check(lut_out_pvld, 0, "pvld_drop");
   endtask

   function automatic int rnd_addr();
      case ($urandom_range(0, 3))
         0:       return $urandom_range(60, 70);
         1:       return $urandom_range(250, 260);
         default: return $urandom_range(0, 511);
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int viol, acc0;
      logic rs;
      rstn = 1'b0; idx_in_pvld = 1'b0; idx_in_pd = '0; lut_out_prdy = 1'b0;
      cfg_pvld = 1'b0; cfg_wr = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      tick(); tick();
      // Reset state
      check(idx_in_prdy, 0, "rst_idx_prdy");
      check(cfg_prdy, 0, "rst_cfg_prdy");
      check(lut_out_pvld, 0, "rst_pvld");
      check(lut_out_pd, 0, "rst_pd");
      check({ram_rd_en, ram_wr_en, ram_sel, ram_addr, ram_wdata}, 0, "rst_ram");
      check({cfg_rdata_pvld, cfg_rdata}, 0, "rst_cfg_rdata");
      rstn = 1'b1;
      tick();

      // LO addr 10 with programmed neighbours
      cfg_write(1'b1, 10, 16'h1234);
      cfg_write(1'b1, 11, 16'h5678);
      cfg_read(1'b1, 10);
      run_pkt(mk_pd(1'b1, 10, 1'b0, 3), 0, 1'b0, '0, 1'b0);
      check(lut_out_pd[31:0], 32'h5678_1234, "lo10_pair");

      // Clamp boundaries
      run_pkt(mk_pd(1'b0, 64, 1'b1, 300), 0, 1'b0, '0, 1'b0);
      run_pkt(mk_pd(1'b1, 255, 1'b0, 63), 0, 1'b0, '0, 1'b0);
      run_pkt(mk_pd(1'b1, 256, 1'b0, 0), 0, 1'b0, '0, 1'b0);

      // Simultaneous cfg write and idx request: cfg first
      cfg_pvld = 1'b1; cfg_wr = 1'b1; cfg_sel = 1'b0; cfg_addr = 9'd5; cfg_wdata = 16'hBEEF;
      idx_in_pvld = 1'b1; idx_in_pd = mk_pd(1'b0, 4, 1'b0, 5);
      #1;
      check(cfg_prdy, 1, "coll_cfg_prdy");
      check(idx_in_prdy, 0, "coll_idx_prdy");
      acc0 = cyc;
      tick();
      cfg_pvld = 1'b0;
      check(ram_wr_en, 1, "coll_wr_strobe");
      check({ram_sel, ram_addr, ram_wdata}, {1'b0, 9'd5, 16'hBEEF}, "coll_wr_fields");
      check(idx_in_prdy, 0, "coll_idx_wait");
      sh_le[5] = 16'hBEEF; sh_le_v[5] = 1'b1;
      run_pkt(mk_pd(1'b0, 4, 1'b0, 5), 0, 1'b0, '0, 1'b0);
      check(last_acc, acc0 + 2, "coll_idx_accept_cycle");
      cfg_read(1'b0, 5);

      // Output backpressure, then back-to-back accept
      run_pkt(mk_pd(1'b0, 7, 1'b1, 128), 5, 1'b1, mk_pd(1'b1, 511, 1'b0, 65), 1'b0);
      run_pkt(mk_pd(1'b1, 511, 1'b0, 65), 0, 1'b0, '0, 1'b1);

      // Reset in the middle of the read sequence
      idx_in_pvld = 1'b1; idx_in_pd = mk_pd(1'b1, 100, 1'b0, 20);
      #1;
      check(idx_in_prdy, 1, "mid_rst_accept");
      tick();
      idx_in_pvld = 1'b0;
      check(ram_rd_en, 1, "mid_rst_rd_active");
      rstn = 1'b0;
      tick();
      check(lut_out_pvld, 0, "mid_rst_pvld");
      check(lut_out_pd, 0, "mid_rst_pd");
      check({ram_rd_en, ram_wr_en, ram_sel, ram_addr, ram_wdata}, 0, "mid_rst_ram");
      check({cfg_rdata_pvld, idx_in_prdy, cfg_prdy}, 0, "mid_rst_hs");
      rstn = 1'b1;
      tick();
      check({lut_out_pvld, ram_rd_en}, 0, "post_rst_idle");
      run_pkt(mk_pd(1'b1, 100, 1'b0, 20), 0, 1'b0, '0, 1'b0);

      // Randomised traffic
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
               cfg_write(rs, $urandom_range(0, rs ? 256 : 64), 16'($urandom));
            else
               cfg_read(rs, $urandom_range(0, rs ? 256 : 64));
         end
         run_pkt(mk_pd(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr()),
                 $urandom_range(0, 3), 1'b0, '0, 1'b0);
      end

      // Whole-run properties
      viol = 0;
      foreach (rd_log[i]) if (rd_log[i].addr > (rd_log[i].sel ? 256 : 64)) viol++;
      check(viol, 0, "ram_addr_bound");
      check({both_seen}, 0, "rd_wr_exclusive");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
